// File: rtl/instr_mem_if.sv
// Load and fetch bundle between the fetch stage and instr_mem_loadable.
// master drives load/fetch requests; slave returns the fetched word.
interface instr_mem_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  load_en;
  logic [WORD_WIDTH-1:0] load_addr;
  logic [WORD_WIDTH-1:0] load_data;
  logic                  load_done;
  logic                  fetch_req;
  logic [WORD_WIDTH-1:0] fetch_addr;
  logic                  stall;
  logic                  ready;
  logic [WORD_WIDTH-1:0] instruction;
  logic                  instr_valid;
  logic                  fetch_err;

  modport master (
    output load_en, load_addr, load_data, load_done,
    output fetch_req, fetch_addr, stall,
    input  ready, instruction, instr_valid, fetch_err
  );

  modport slave (
    input  load_en, load_addr, load_data, load_done,
    input  fetch_req, fetch_addr, stall,
    output ready, instruction, instr_valid, fetch_err
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: LOAD phase fills the array,
// RUN phase serves registered byte-addressed fetches.
module instr_mem_loadable #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  instr_mem_if.slave bus
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic             ld_ok;
  logic             fe_ok;
  logic [IDX_W-1:0] ld_idx;
  logic [IDX_W-1:0] fe_idx;
  logic             accept;

  logic [WORD_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  err_q;

  assign ld_idx = bus.load_addr[IDX_W+1:2];
  assign fe_idx = bus.fetch_addr[IDX_W+1:2];

  // Aligned and no bits set above the word index: no wrap into the array.
  assign ld_ok = (bus.load_addr[1:0] == 2'b00)
              && ((bus.load_addr >> (IDX_W + 2)) == '0);
  assign fe_ok = (bus.fetch_addr[1:0] == 2'b00)
              && ((bus.fetch_addr >> (IDX_W + 2)) == '0);

  assign accept = (state_q == RUN) && bus.fetch_req && !bus.stall;

  // Next state: LOAD until load_done, then RUN until reset.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == LOAD): if (bus.load_done) state_d = RUN;
      default:           state_d = state_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Array writes; never cleared so a program survives reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == LOAD && bus.load_en && ld_ok)
      mem[ld_idx] <= bus.load_data;
  end

  // Fetch output registers; stall freezes all three.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      if (fe_ok) begin
        instr_q <= mem[fe_idx];
        err_q   <= 1'b0;
      end else begin
        instr_q <= '0;
        err_q   <= 1'b1;
      end
    end else if (!bus.stall) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  assign bus.ready       = (state_q == RUN);
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable (DEPTH = 64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instr_mem_loadable;

  localparam logic [31:0] W0   = 32'hE3A00014;
  localparam logic [31:0] W4   = 32'hE3A01A01;
  localparam logic [31:0] W12  = 32'hE0923002;
  localparam logic [31:0] W252 = 32'hEAFFFFFE;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total;

  instr_mem_if #(.WORD_WIDTH(32)) bus ();

  instr_mem_loadable #(
    .WORD_WIDTH(32),
    .DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load_en    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_done  = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (bus.ready !== 1'b0)
      $display("FAIL reset_ready got=%b exp=0", bus.ready);
    else pass_cnt++;
    total++;
    if (bus.instruction !== 32'h0)
      $display("FAIL reset_instr got=%h exp=0", bus.instruction);
    else pass_cnt++;
    total++;
    if (bus.instr_valid !== 1'b0)
      $display("FAIL reset_valid got=%b exp=0", bus.instr_valid);
    else pass_cnt++;
    total++;
    if (bus.fetch_err !== 1'b0)
      $display("FAIL reset_err got=%b exp=0", bus.fetch_err);
    else pass_cnt++;
  endtask

  task automatic test_fetch_in_load();
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0);
      total++;
      if (bus.instr_valid !== 1'b0 || bus.ready !== 1'b0)
        $display("FAIL load_fetch valid=%b ready=%b exp=0/0",
                 bus.instr_valid, bus.ready);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_load();
    load_word(32'd0, W0);
    load_word(32'd4, W4);
    load_word(32'd252, W252);
    load_word(32'd2, 32'h11111111);
    load_word(32'd256, 32'hDEADBEEF);
    load_word(32'hFFFFFFFC, 32'h22222222);
    total++;
    if (bus.ready !== 1'b0)
      $display("FAIL pre_done_ready got=%b exp=0", bus.ready);
    else pass_cnt++;
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL post_done_ready got=%b exp=1", bus.ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fetch(32'd0);
    total++;
    if (bus.instruction !== W0 || bus.instr_valid !== 1'b1
        || bus.fetch_err !== 1'b0)
      $display("FAIL b2b_w0 got=%h/%b/%b exp=%h/1/0",
               bus.instruction, bus.instr_valid, bus.fetch_err, W0);
    else pass_cnt++;
    fetch(32'd4);
    total++;
    if (bus.instruction !== W4 || bus.instr_valid !== 1'b1
        || bus.fetch_err !== 1'b0)
      $display("FAIL b2b_w4 got=%h/%b/%b exp=%h/1/0",
               bus.instruction, bus.instr_valid, bus.fetch_err, W4);
    else pass_cnt++;
    idle();
    step();
    total++;
    if (bus.instruction !== W4 || bus.instr_valid !== 1'b0
        || bus.fetch_err !== 1'b0)
      $display("FAIL no_req_hold got=%h/%b/%b exp=%h/0/0",
               bus.instruction, bus.instr_valid, bus.fetch_err, W4);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [31:0] bad [3];
    bad[0] = 32'd256;
    bad[1] = 32'hFFFFFFFC;
    bad[2] = 32'd6;
    fetch(32'd252);
    total++;
    if (bus.instruction !== W252 || bus.instr_valid !== 1'b1
        || bus.fetch_err !== 1'b0)
      $display("FAIL bnd_252 got=%h/%b/%b exp=%h/1/0",
               bus.instruction, bus.instr_valid, bus.fetch_err, W252);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      fetch(bad[i]);
      total++;
      if (bus.instruction !== 32'h0 || bus.instr_valid !== 1'b1
          || bus.fetch_err !== 1'b1)
        $display("FAIL bnd_err addr=%h got=%h/%b/%b exp=0/1/1", bad[i],
                 bus.instruction, bus.instr_valid, bus.fetch_err);
      else pass_cnt++;
    end
    fetch(32'd0);
    total++;
    if (bus.instruction !== W0 || bus.fetch_err !== 1'b0)
      $display("FAIL dropped_loads got=%h/%b exp=%h/0",
               bus.instruction, bus.fetch_err, W0);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_stall();
    fetch(32'd0);
    bus.stall      = 1'b1;
    bus.fetch_addr = 32'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.instruction !== W0 || bus.instr_valid !== 1'b1
          || bus.fetch_err !== 1'b0)
        $display("FAIL stall_hold cyc=%0d got=%h/%b/%b exp=%h/1/0", i,
                 bus.instruction, bus.instr_valid, bus.fetch_err, W0);
      else pass_cnt++;
    end
    bus.stall = 1'b0;
    step();
    total++;
    if (bus.instruction !== W4 || bus.instr_valid !== 1'b1)
      $display("FAIL stall_resume got=%h/%b exp=%h/1",
               bus.instruction, bus.instr_valid, W4);
    else pass_cnt++;
    fetch(32'd6);
    bus.stall     = 1'b1;
    bus.fetch_req = 1'b0;
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.fetch_err !== 1'b1)
      $display("FAIL stall_err_hold got=%b/%b exp=1/1",
               bus.instr_valid, bus.fetch_err);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_reset_mid_run();
    fetch(32'd0);
    bus.fetch_addr = 32'd4;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.instruction !== 32'h0 || bus.instr_valid !== 1'b0
        || bus.fetch_err !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL mid_rst got=%h/%b/%b rdy=%b exp=0/0/0 rdy=0",
               bus.instruction, bus.instr_valid, bus.fetch_err, bus.ready);
    else pass_cnt++;
    step();
    total++;
    if (bus.instr_valid !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL mid_rst_load got=%b rdy=%b exp=0 rdy=0",
               bus.instr_valid, bus.ready);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_same_cycle_done();
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd12;
    bus.load_data = W12;
    bus.load_done = 1'b1;
    step();
    idle();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL same_done_ready got=%b exp=1", bus.ready);
    else pass_cnt++;
    fetch(32'd0);
    total++;
    if (bus.instruction !== W0 || bus.instr_valid !== 1'b1)
      $display("FAIL survive_rst got=%h/%b exp=%h/1",
               bus.instruction, bus.instr_valid, W0);
    else pass_cnt++;
    fetch(32'd12);
    total++;
    if (bus.instruction !== W12 || bus.fetch_err !== 1'b0)
      $display("FAIL same_done_w12 got=%h/%b exp=%h/0",
               bus.instruction, bus.fetch_err, W12);
    else pass_cnt++;
    idle();
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd12;
    bus.load_data = 32'h0;
    bus.load_done = 1'b1;
    step();
    idle();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL run_done_ready got=%b exp=1", bus.ready);
    else pass_cnt++;
    fetch(32'd12);
    total++;
    if (bus.instruction !== W12)
      $display("FAIL run_load_ignored got=%h exp=%h",
               bus.instruction, W12);
    else pass_cnt++;
    idle();
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_fetch_in_load();
    test_load();
    test_back_to_back();
    test_boundaries();
    test_stall();
    test_reset_mid_run();
    test_same_cycle_done();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
